fetch_prefetch_queue: RTL
=========================

Name: fetch_prefetch_queue

Overview:
- Next-generation instruction fetch unit.
- Issues sequential instruction reads ahead of decode through the single-outstanding AXI user interface.
- Buffers returned {PC, INST} pairs in a parametrised FIFO and hands them to ID with a valid/ready handshake.
- On a jump/branch or exception redirect, flushes the queue and drops any in-flight response, so the pipeline stays fed without per-instruction stalls.

Parameters:
ADDR_W, 32, PC/address width
INST_W, 32, instruction width
DEPTH, 4, queue entries (power of two, ≥2)
START_ADDR, 32'h00000000, reset PC
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
jbr_bus  in  ADDR_W+1  {taken, target}; one-cycle redirect pulse
exc_bus  in  ADDR_W+1  {valid, target}; one-cycle redirect pulse, beats jbr_bus
axi_start  out  1  one-cycle read request
axi_addr  out  ADDR_W  read address, held from request until the next request
axi_done  in  1  read data valid, one cycle
axi_rdata  in  INST_W  read data
axi_busy  in  1  AXI master cannot accept a request
IF_valid  out  1  queue head valid
ID_ready  in  1  ID accepts the head this cycle
IF_ID_bus  out  ADDR_W+INST_W  {pc, inst} of the head
IF_pc  out  ADDR_W  head PC (debug)
IF_inst  out  INST_W  head instruction (debug)
fifo_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, fetch_pc=START_ADDR, discard=0, queue empty.
  - axi_start=0, axi_addr=START_ADDR, IF_valid=0, IF_ID_bus=0, fifo_count=0.
  - Asserting reset mid-transaction abandons it; a later axi_done arrives in IDLE and is ignored.
- Redirect:
  - redir = exc_valid | jbr_taken; target = exc_valid ? exc target : jbr target.
  - On redir: fetch_pc<=target; queue flushed (count=0; ID_ready pop and any push that cycle ignored).
  - If state is REQ or WAIT, or axi_done is high that cycle: discard<=1, unless axi_done is high in WAIT that same cycle, in which case that response is dropped and discard stays 0.
- Request FSM:
  - IDLE: go to REQ when !redir && !axi_busy && !discard && fifo_count<DEPTH. On that transition axi_addr<=fetch_pc and fetch_pc<=fetch_pc+PC_STEP (mod 2^ADDR_W).
  - REQ: axi_start=1 for exactly this one cycle; go to WAIT unconditionally.
  - WAIT: on axi_done, go to IDLE. If discard=0 and no redir, push {axi_addr, axi_rdata}; if discard=1, clear discard and drop the data.
  - axi_done in IDLE or REQ is ignored. An axi_done in IDLE while discard=1 clears discard (stale-response catch-up).
  - A redirect in IDLE with discard=0 blocks issue that cycle only.
- Queue:
  - Circular buffer; wrap-around of read/write pointers modulo DEPTH.
  - Pop when IF_valid && ID_ready && !redir. A simultaneous push and pop leaves count unchanged.
  - Overflow is impossible: issue requires count<DEPTH with one outstanding request. A push while full is an assertion error.
  - IF_valid = count!=0. IF_ID_bus/IF_pc/IF_inst show the head when IF_valid, else 0.
- Latency:
  - Redirect at edge N → axi_start=1 with axi_addr=target in cycle N+2 (if not busy, nothing pending).
  - axi_done in cycle M → IF_valid/head visible in cycle M+1.
  - Steady state with 1-cycle memory: one instruction per 3 cycles.

Test Plan:
- Reset release, memory returns word+0x100 after 2 cycles, ID_ready=1 → axi_addr 0,4,8…; IF_ID_bus {0x0,0x100},{0x4,0x104}… in order; axi_start never high in consecutive cycles.
- ID_ready=0, DEPTH=4 → exactly 4 requests (0x0–0xC), fifo_count=4, no 5th axi_start. Then pop one → next request addr 0x10; pointers wrap correctly over ≥3 queue wraps.
- jbr_bus={1,0x400} while WAIT for 0x8 → queue flushed, the 0x8 response dropped (never on IF_ID_bus), next axi_addr=0x400, first output {0x400,…}.
- exc_bus={1,0x380} and jbr_bus={1,0x400} in the same cycle as axi_done → 0x380 chosen, the response dropped, a pop that cycle ignored, fifo_count=0.
- axi_busy=1 for 5 cycles → no axi_start; the request issues the cycle after busy drops. A spurious axi_done in IDLE → no push.
- resetn pulled low asynchronously in WAIT → all outputs return to reset values immediately; the late axi_done is ignored; fetch restarts at START_ADDR.

Source files
------------

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch unit bundle: redirect inputs, single-outstanding AXI read user port,
// and the IF->ID valid/ready handoff. master = fetch unit, slave = environment.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W:0]          jbr_bus;
  logic [ADDR_W:0]          exc_bus;
  logic                     axi_start;
  logic [ADDR_W-1:0]        axi_addr;
  logic                     axi_done;
  logic [INST_W-1:0]        axi_rdata;
  logic                     axi_busy;
  logic                     IF_valid;
  logic                     ID_ready;
  logic [ADDR_W+INST_W-1:0] IF_ID_bus;
  logic [ADDR_W-1:0]        IF_pc;
  logic [INST_W-1:0]        IF_inst;
  logic [CNT_W-1:0]         fifo_count;

  modport master (
    input  jbr_bus, exc_bus, axi_done, axi_rdata, axi_busy, ID_ready,
    output axi_start, axi_addr, IF_valid, IF_ID_bus, IF_pc, IF_inst, fifo_count
  );
  modport slave (
    output jbr_bus, exc_bus, axi_done, axi_rdata, axi_busy, ID_ready,
    input  axi_start, axi_addr, IF_valid, IF_ID_bus, IF_pc, IF_inst, fifo_count
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding read at a time, returned
// {pc, inst} pairs buffered in a circular queue, flushed on jump/exception redirect.
module fetch_prefetch_queue #(
  parameter int              ADDR_W     = 32,
  parameter int              INST_W     = 32,
  parameter int              DEPTH      = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int              PC_STEP    = 4
) (
  input logic                   clk,
  input logic                   resetn,
  fetch_prefetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INST_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              discard, discard_n;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  head;

  logic              exc_vld, jbr_tkn, redir;
  logic [ADDR_W-1:0] target;
  logic              full, issue, push, pop;

  assign exc_vld = bus.exc_bus[ADDR_W];
  assign jbr_tkn = bus.jbr_bus[ADDR_W];
  assign redir   = exc_vld | jbr_tkn;
  assign target  = exc_vld ? bus.exc_bus[ADDR_W-1:0] : bus.jbr_bus[ADDR_W-1:0];

  assign full  = (count == CNT_W'(DEPTH));
  assign issue = (state == IDLE) && !redir && !bus.axi_busy && !discard && !full;
  assign push  = (state == WAIT) && bus.axi_done && !discard && !redir;
  assign pop   = (count != '0) && bus.ID_ready && !redir;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = addr_q;
    discard_n  = discard;
    case (state)
      IDLE: if (issue) begin
        state_n    = REQ;
        addr_n     = fetch_pc;
        fetch_pc_n = fetch_pc + ADDR_W'(PC_STEP);
      end
      REQ:     state_n = WAIT;
      WAIT:    if (bus.axi_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A response landing in WAIT on the redirect cycle is dropped right here,
    // so nothing is left in flight to discard later.
    if (redir) begin
      fetch_pc_n = target;
      if (state != IDLE || bus.axi_done)
        discard_n = !(state == WAIT && bus.axi_done);
    end else if (bus.axi_done && state != REQ && discard) begin
      discard_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      fetch_pc <= START_ADDR;
      addr_q   <= START_ADDR;
      discard  <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      addr_q   <= addr_n;
      discard  <= discard_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redir) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {addr_q, bus.axi_rdata};
  end

  always @(posedge clk) begin
    if (resetn && push && !pop) assert (!full);
  end

  assign head           = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.axi_start  = (state == REQ);
  assign bus.axi_addr   = addr_q;
  assign bus.IF_valid   = (count != '0);
  assign bus.IF_ID_bus  = head;
  assign bus.IF_pc      = head[ENT_W-1:INST_W];
  assign bus.IF_inst    = head[INST_W-1:0];
  assign bus.fifo_count = count;
endmodule
